// File: rtl/gsu_map_pkg.sv
// Shared definitions for the programmable GSU address map:
// register field indices, flag bit positions and the region config record.
package gsu_map_pkg;

  localparam logic [3:0] FLD_BANK_LO = 4'd0;
  localparam logic [3:0] FLD_BANK_HI = 4'd1;
  localparam logic [3:0] FLD_OFF     = 4'd2;
  localparam logic [3:0] FLD_FLAGS   = 4'd3;
  localparam logic [3:0] FLD_BASE0   = 4'd4;
  localparam logic [3:0] FLD_BASE1   = 4'd5;
  localparam logic [3:0] FLD_BASE2   = 4'd6;
  localparam logic [3:0] FLD_MASK0   = 4'd7;
  localparam logic [3:0] FLD_MASK1   = 4'd8;
  localparam logic [3:0] FLD_MASK2   = 4'd9;

  localparam int FLG_EN    = 0;
  localparam int FLG_ROM   = 1;
  localparam int FLG_SAVE  = 2;
  localparam int FLG_WR    = 3;
  localparam int FLG_LOROM = 4;

  typedef struct packed {
    logic [7:0]  bank_lo;
    logic [7:0]  bank_hi;
    logic [3:0]  off_match;
    logic [3:0]  off_mask;
    logic [4:0]  flags;
    logic [23:0] base;
    logic [23:0] mask;
  } region_cfg_t;

  function automatic logic [7:0] cfg_read(region_cfg_t c, logic [3:0] f);
    logic [7:0] v;
    v = '0;
    case (f)
      FLD_BANK_LO: v = c.bank_lo;
      FLD_BANK_HI: v = c.bank_hi;
      FLD_OFF:     v = {c.off_match, c.off_mask};
      FLD_FLAGS:   v = {3'b000, c.flags};
      FLD_BASE0:   v = c.base[7:0];
      FLD_BASE1:   v = c.base[15:8];
      FLD_BASE2:   v = c.base[23:16];
      FLD_MASK0:   v = c.mask[7:0];
      FLD_MASK1:   v = c.mask[15:8];
      FLD_MASK2:   v = c.mask[23:16];
      default:     v = '0;
    endcase
    return v;
  endfunction

  function automatic region_cfg_t cfg_write(region_cfg_t c,
                                            logic [3:0] f,
                                            logic [7:0] d);
    region_cfg_t n;
    n = c;
    case (f)
      FLD_BANK_LO: n.bank_lo = d;
      FLD_BANK_HI: n.bank_hi = d;
      FLD_OFF:     {n.off_match, n.off_mask} = d;
      FLD_FLAGS:   n.flags = d[4:0];
      FLD_BASE0:   n.base[7:0] = d;
      FLD_BASE1:   n.base[15:8] = d;
      FLD_BASE2:   n.base[23:16] = d;
      FLD_MASK0:   n.mask[7:0] = d;
      FLD_MASK1:   n.mask[15:8] = d;
      FLD_MASK2:   n.mask[23:16] = d;
      default:     n = c;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/gsu_map_region_match.sv
// Single decode window matcher: enable, bank range and offset nibble filter.
module gsu_map_region_match
  import gsu_map_pkg::*;
(
  input  region_cfg_t cfg_i,
  input  logic [7:0]  bank_i,
  input  logic [3:0]  nib_i,
  output logic        match_o
);

  logic in_bank;
  logic off_ok;

  assign in_bank = (bank_i >= cfg_i.bank_lo) && (bank_i <= cfg_i.bank_hi);
  assign off_ok  = (nib_i & cfg_i.off_mask) ==
                   (cfg_i.off_match & cfg_i.off_mask);
  assign match_o = cfg_i.flags[FLG_EN] && in_bank && off_ok;

endmodule

// File: rtl/gsu_address_map.sv
// Programmable two-stage SNES->physical address decoder with shadowed
// configuration, atomic commit and an address-stability qualifier.
module gsu_address_map
  import gsu_map_pkg::*;
#(
  parameter int N_REGIONS     = 4,
  parameter int RIDX_W        = 2,
  parameter int ADDR_W        = 24,
  parameter int STABLE_CYCLES = 2
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [ADDR_W-1:0] SNES_ADDR,
  input  logic              mcu_wr,
  input  logic              mcu_rd,
  input  logic [RIDX_W+3:0] mcu_addr,
  input  logic [7:0]        mcu_data,
  output logic [7:0]        mcu_rdata,
  input  logic              mcu_commit,
  output logic              commit_ack,
  output logic [ADDR_W-1:0] ROM_ADDR,
  output logic              ROM_HIT,
  output logic              IS_ROM,
  output logic              IS_SAVERAM,
  output logic              IS_WRITABLE,
  output logic [RIDX_W-1:0] region_idx,
  output logic              addr_stable
);

  region_cfg_t shadow_q [N_REGIONS];
  region_cfg_t shadow_d [N_REGIONS];
  region_cfg_t active_q [N_REGIONS];
  logic [7:0]  rdata_q;
  logic        ack_q;

  logic [RIDX_W-1:0] m_rgn;
  logic [3:0]        m_fld;

  assign m_rgn = mcu_addr[RIDX_W+3:4];
  assign m_fld = mcu_addr[3:0];

  // Commit copies shadow_d so a same-cycle write lands in the active bank
  always_comb begin
    shadow_d = shadow_q;
    if (mcu_wr)
      shadow_d[m_rgn] = cfg_write(shadow_q[m_rgn], m_fld, mcu_data);
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < N_REGIONS; i++) begin
        shadow_q[i] <= '0;
        active_q[i] <= '0;
      end
      rdata_q <= '0;
      ack_q   <= 1'b0;
    end else begin
      shadow_q <= shadow_d;
      if (mcu_commit)
        active_q <= shadow_d;
      if (mcu_rd)
        rdata_q <= cfg_read(shadow_q[m_rgn], m_fld);
      ack_q <= mcu_commit;
    end
  end

  logic [N_REGIONS-1:0] match;

  for (genvar g = 0; g < N_REGIONS; g++) begin : g_match
    gsu_map_region_match u_match (
      .cfg_i   (active_q[g]),
      .bank_i  (SNES_ADDR[23:16]),
      .nib_i   (SNES_ADDR[15:12]),
      .match_o (match[g])
    );
  end

  logic              win_hit, win_rom, win_sav, win_wr, win_lorom;
  logic [RIDX_W-1:0] win_idx;
  logic [7:0]        win_bank_lo;
  logic [23:0]       win_base, win_mask;

  // Descending scan leaves the lowest matching index as the winner
  always_comb begin
    win_hit     = 1'b0;
    win_idx     = '0;
    win_rom     = 1'b0;
    win_sav     = 1'b0;
    win_wr      = 1'b0;
    win_lorom   = 1'b0;
    win_bank_lo = '0;
    win_base    = '0;
    win_mask    = '0;
    for (int i = N_REGIONS - 1; i >= 0; i--) begin
      if (match[i]) begin
        win_hit     = 1'b1;
        win_idx     = RIDX_W'(i);
        win_rom     = active_q[i].flags[FLG_ROM];
        win_sav     = active_q[i].flags[FLG_SAVE];
        win_wr      = active_q[i].flags[FLG_WR];
        win_lorom   = active_q[i].flags[FLG_LOROM];
        win_bank_lo = active_q[i].bank_lo;
        win_base    = active_q[i].base;
        win_mask    = active_q[i].mask;
      end
    end
  end

  logic [ADDR_W-1:0] s1_addr_q;
  logic              s1_hit_q, s1_rom_q, s1_sav_q, s1_wr_q, s1_lorom_q;
  logic [RIDX_W-1:0] s1_idx_q;
  logic [7:0]        s1_bank_lo_q;
  logic [23:0]       s1_base_q, s1_mask_q;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      s1_addr_q    <= '0;
      s1_hit_q     <= 1'b0;
      s1_rom_q     <= 1'b0;
      s1_sav_q     <= 1'b0;
      s1_wr_q      <= 1'b0;
      s1_lorom_q   <= 1'b0;
      s1_idx_q     <= '0;
      s1_bank_lo_q <= '0;
      s1_base_q    <= '0;
      s1_mask_q    <= '0;
    end else begin
      s1_addr_q    <= SNES_ADDR;
      s1_hit_q     <= win_hit;
      s1_rom_q     <= win_rom;
      s1_sav_q     <= win_sav;
      s1_wr_q      <= win_wr;
      s1_lorom_q   <= win_lorom;
      s1_idx_q     <= win_idx;
      s1_bank_lo_q <= win_bank_lo;
      s1_base_q    <= win_base;
      s1_mask_q    <= win_mask;
    end
  end

  logic [7:0]        rel_bank;
  logic [23:0]       off, xlat;
  logic [ADDR_W-1:0] rom_addr_d;

  assign rel_bank = s1_addr_q[23:16] - s1_bank_lo_q;
  assign off      = s1_lorom_q ? {1'b0, rel_bank, s1_addr_q[14:0]}
                               : {rel_bank, s1_addr_q[15:0]};
  assign xlat     = s1_base_q | (off & s1_mask_q);
  assign rom_addr_d = s1_hit_q ? ADDR_W'(xlat) : s1_addr_q;

  logic [ADDR_W-1:0] rom_addr_q;
  logic              rom_hit_q, is_rom_q, is_sav_q, is_wr_q;
  logic [RIDX_W-1:0] idx_q;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      rom_addr_q <= '0;
      rom_hit_q  <= 1'b0;
      is_rom_q   <= 1'b0;
      is_sav_q   <= 1'b0;
      is_wr_q    <= 1'b0;
      idx_q      <= '0;
    end else begin
      rom_addr_q <= rom_addr_d;
      rom_hit_q  <= s1_hit_q & (s1_rom_q | s1_wr_q);
      is_rom_q   <= s1_rom_q;
      is_sav_q   <= s1_sav_q;
      is_wr_q    <= s1_wr_q;
      idx_q      <= s1_idx_q;
    end
  end

  logic [ADDR_W-1:0] prev_q;
  logic [3:0]        cnt_q, cnt_d;
  logic              stable_q;

  always_comb begin
    cnt_d = '0;
    if (SNES_ADDR == prev_q)
      cnt_d = (cnt_q == 4'hF) ? cnt_q : cnt_q + 4'd1;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      prev_q   <= '0;
      cnt_q    <= '0;
      stable_q <= 1'b0;
    end else begin
      prev_q   <= SNES_ADDR;
      cnt_q    <= cnt_d;
      stable_q <= cnt_d >= 4'(STABLE_CYCLES - 1);
    end
  end

  assign mcu_rdata   = rdata_q;
  assign commit_ack  = ack_q;
  assign ROM_ADDR    = rom_addr_q;
  assign ROM_HIT     = rom_hit_q;
  assign IS_ROM      = is_rom_q;
  assign IS_SAVERAM  = is_sav_q;
  assign IS_WRITABLE = is_wr_q;
  assign region_idx  = idx_q;
  assign addr_stable = stable_q;

endmodule

// File: tb/tb_gsu_address_map.sv
// Randomised self-checking bench for gsu_address_map against a
// region-table reference model with a two-deep result queue.
module tb_gsu_address_map;

  localparam int STABLE = 2;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic [23:0] SNES_ADDR = '0;
  logic        mcu_wr = 1'b0, mcu_rd = 1'b0, mcu_commit = 1'b0;
  logic [5:0]  mcu_addr = '0;
  logic [7:0]  mcu_data = '0;
  logic [7:0]  mcu_rdata;
  logic        commit_ack;
  logic [23:0] ROM_ADDR;
  logic        ROM_HIT, IS_ROM, IS_SAVERAM, IS_WRITABLE, addr_stable;
  logic [1:0]  region_idx;

  gsu_address_map #(
    .N_REGIONS(4), .RIDX_W(2), .ADDR_W(24), .STABLE_CYCLES(STABLE)
  ) dut (
    .CLK(CLK), .RST(RST), .SNES_ADDR(SNES_ADDR),
    .mcu_wr(mcu_wr), .mcu_rd(mcu_rd), .mcu_addr(mcu_addr),
    .mcu_data(mcu_data), .mcu_rdata(mcu_rdata),
    .mcu_commit(mcu_commit), .commit_ack(commit_ack),
    .ROM_ADDR(ROM_ADDR), .ROM_HIT(ROM_HIT), .IS_ROM(IS_ROM),
    .IS_SAVERAM(IS_SAVERAM), .IS_WRITABLE(IS_WRITABLE),
    .region_idx(region_idx), .addr_stable(addr_stable)
  );

  always #5 CLK = ~CLK;

  wire [30:0] dutv = {ROM_ADDR, ROM_HIT, IS_ROM, IS_SAVERAM,
                      IS_WRITABLE, region_idx, addr_stable};

  int checks = 0;
  int errors = 0;

  typedef struct {
    int unsigned a, rh, rom, sav, wr, idx;
  } res_t;

  int unsigned sh [4][10];
  int unsigned act[4][10];
  int unsigned hist[$];
  res_t        p1, p2;
  int unsigned m_rdata, m_ack, m_stable;

  function automatic res_t decode(int unsigned a);
    res_t r;
    int unsigned bank, nib, om, mk, rel, off, base, mask;
    r = '{a: a, default: 0};
    bank = a / 65536;
    nib  = (a / 4096) % 16;
    for (int i = 0; i < 4; i++) begin
      om = act[i][2] / 16;
      mk = act[i][2] % 16;
      if ((act[i][3] % 2 == 1) && bank >= act[i][0] && bank <= act[i][1]
          && ((nib & mk) == (om & mk))) begin
        rel  = bank - act[i][0];
        off  = ((act[i][3] / 16) % 2 == 1) ? rel * 32768 + a % 32768
                                           : rel * 65536 + a % 65536;
        base = act[i][4] + act[i][5] * 256 + act[i][6] * 65536;
        mask = act[i][7] + act[i][8] * 256 + act[i][9] * 65536;
        r.a   = (base | (off & mask)) % 32'h0100_0000;
        r.rom = (act[i][3] / 2) % 2;
        r.sav = (act[i][3] / 4) % 2;
        r.wr  = (act[i][3] / 8) % 2;
        r.rh  = (r.rom | r.wr);
        r.idx = i;
        return r;
      end
    end
    return r;
  endfunction

  function automatic logic [30:0] expv();
    return {24'(p2.a), 1'(p2.rh), 1'(p2.rom), 1'(p2.sav),
            1'(p2.wr), 2'(p2.idx), 1'(m_stable)};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 4; i++)
      for (int f = 0; f < 10; f++) begin
        sh[i][f]  = 0;
        act[i][f] = 0;
      end
    hist.delete();
    hist.push_back(0);
    p1 = '{default: 0};
    p2 = '{default: 0};
    m_rdata = 0;
    m_ack = 0;
    m_stable = 0;
  endtask

  task automatic cyc();
    res_t d;
    int unsigned r, f;
    bit s;
    d = decode(SNES_ADDR);
    hist.push_back(SNES_ADDR);
    if (hist.size() > 16) void'(hist.pop_front());
    s = (hist.size() >= STABLE);
    for (int k = 1; k < STABLE; k++)
      if (s && hist[hist.size() - 1 - k] != SNES_ADDR) s = 0;
    r = mcu_addr / 16;
    f = mcu_addr % 16;
    if (mcu_rd) m_rdata = (f < 10) ? sh[r][f] : 0;
    if (mcu_wr && f < 10) sh[r][f] = (f == 3) ? mcu_data % 32 : mcu_data;
    if (mcu_commit) act = sh;
    m_ack = mcu_commit;
    @(posedge CLK);
    #1;
    p2 = p1;
    p1 = d;
    m_stable = s;
  endtask

  task automatic prog(int r, int lo, int hi, int off, int fl,
                      int base, int mask);
    int v[10];
    v = '{lo, hi, off, fl, base & 255, (base >> 8) & 255,
          (base >> 16) & 255, mask & 255, (mask >> 8) & 255,
          (mask >> 16) & 255};
    for (int f = 0; f < 10; f++) begin
      mcu_wr = 1'b1;
      mcu_addr = 6'(r * 16 + f);
      mcu_data = 8'(v[f]);
      cyc();
    end
    mcu_wr = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge CLK);
    checks++;
    if (dutv !== '0) begin
      errors++;
      $display("FAIL reset_outputs got %h exp 0", dutv);
    end
    checks++;
    if ({mcu_rdata, commit_ack} !== 9'h0) begin
      errors++;
      $display("FAIL reset_mcu got %h exp 0", {mcu_rdata, commit_ack});
    end
    RST = 1'b0;
    model_reset();
  endtask

  task automatic test_passthrough();
    for (int i = 0; i < 20; i++) begin
      SNES_ADDR = 24'($urandom);
      cyc();
      checks++;
      if (dutv !== expv() || commit_ack !== 1'b0 || ROM_HIT !== 1'b0) begin
        errors++;
        $display("FAIL passthrough got %h ack %b exp %h", dutv,
                 commit_ack, expv());
      end
    end
  endtask

  task automatic test_program();
    prog(0, 8'h00, 8'h3F, 8'h88, 8'h13, 24'h000000, 24'h1FFFFF);
    mcu_commit = 1'b1;
    cyc();
    mcu_commit = 1'b0;
    checks++;
    if (commit_ack !== 1'b1 || m_ack != 1) begin
      errors++;
      $display("FAIL commit_ack_pulse got %b exp 1", commit_ack);
    end
    SNES_ADDR = 24'h01C123;
    cyc();
    checks++;
    if (commit_ack !== 1'b0) begin
      errors++;
      $display("FAIL commit_ack_once got %b exp 0", commit_ack);
    end
    cyc();
    checks++;
    if ({ROM_ADDR, ROM_HIT, IS_ROM, region_idx} !== {24'h00C123, 1'b1,
         1'b1, 2'd0} || dutv !== expv()) begin
      errors++;
      $display("FAIL lorom_xlat got %h hit %b rom %b exp 00c123 1 1",
               ROM_ADDR, ROM_HIT, IS_ROM);
    end
  endtask

  task automatic test_two_regions();
    prog(1, 8'h00, 8'hFF, 8'h00, 8'h05, 24'hE00000, 24'h000000);
    mcu_commit = 1'b1;
    cyc();
    mcu_commit = 1'b0;
    SNES_ADDR = 24'h018000;
    cyc();
    SNES_ADDR = 24'h780010;
    cyc();
    checks++;
    if ({ROM_ADDR, ROM_HIT, region_idx} !== {24'h008000, 1'b1, 2'd0}
        || dutv !== expv()) begin
      errors++;
      $display("FAIL prio_region0 got %h idx %0d exp 008000 idx 0",
               ROM_ADDR, region_idx);
    end
    cyc();
    checks++;
    if ({ROM_ADDR, ROM_HIT, IS_SAVERAM, IS_ROM, region_idx} !==
        {24'hE00000, 1'b0, 1'b1, 1'b0, 2'd1} || dutv !== expv()) begin
      errors++;
      $display("FAIL saveram_region1 got %h sav %b idx %0d exp e00000 1 1",
               ROM_ADDR, IS_SAVERAM, region_idx);
    end
  endtask

  task automatic test_shadow();
    mcu_wr = 1'b1;
    mcu_addr = 6'h03;
    mcu_data = 8'h12;
    cyc();
    mcu_addr = 6'h0C;
    mcu_data = 8'hAB;
    cyc();
    mcu_wr = 1'b0;
    mcu_rd = 1'b1;
    mcu_addr = 6'h03;
    cyc();
    checks++;
    if (mcu_rdata !== 8'h12 || m_rdata != 8'h12) begin
      errors++;
      $display("FAIL shadow_read got %h exp 12", mcu_rdata);
    end
    mcu_addr = 6'h0C;
    cyc();
    mcu_rd = 1'b0;
    checks++;
    if (mcu_rdata !== 8'h00) begin
      errors++;
      $display("FAIL reserved_read got %h exp 00", mcu_rdata);
    end
    SNES_ADDR = 24'h01C123;
    cyc();
    cyc();
    checks++;
    if (ROM_HIT !== 1'b1 || region_idx !== 2'd0 || dutv !== expv()) begin
      errors++;
      $display("FAIL shadow_no_effect got hit %b idx %0d exp 1 0",
               ROM_HIT, region_idx);
    end
  endtask

  task automatic test_commit_stream();
    int kc;
    kc = 4;
    for (int k = 0; k < 10; k++) begin
      SNES_ADDR = {2'b00, 6'($urandom), 1'b1, 15'($urandom)};
      mcu_commit = (k == kc);
      cyc();
      mcu_commit = 1'b0;
      checks++;
      if (dutv !== expv()) begin
        errors++;
        $display("FAIL commit_stream[%0d] got %h exp %h", k, dutv, expv());
      end
      if (k == kc + 1) begin
        checks++;
        if (region_idx !== 2'd0 || ROM_HIT !== 1'b1) begin
          errors++;
          $display("FAIL commit_old_cfg got idx %0d exp 0", region_idx);
        end
      end
      if (k == kc + 2) begin
        checks++;
        if (region_idx !== 2'd1 || IS_SAVERAM !== 1'b1) begin
          errors++;
          $display("FAIL commit_new_cfg got idx %0d exp 1", region_idx);
        end
      end
    end
  endtask

  task automatic test_stable();
    logic [23:0] x;
    bit exp_s[8];
    exp_s = '{0, 1, 1, 1, 0, 0, 1, 1};
    x = SNES_ADDR ^ 24'h5A5A5A;
    for (int k = 0; k < 8; k++) begin
      SNES_ADDR = (k == 4) ? (x ^ 24'h1) : x;
      cyc();
      checks++;
      if (addr_stable !== exp_s[k] || m_stable != exp_s[k]) begin
        errors++;
        $display("FAIL stable[%0d] got %b exp %b", k, addr_stable,
                 exp_s[k]);
      end
    end
  endtask

  task automatic test_random();
    int lo[4], hi[4], j, fl;
    for (int r = 0; r < 4; r++) begin
      lo[r] = $urandom_range(0, 200);
      hi[r] = lo[r] + $urandom_range(0, 55);
      fl = $urandom_range(0, 31);
      if ($urandom_range(0, 3) != 0) fl = fl | 1;
      prog(r, lo[r], hi[r], $urandom_range(0, 255), fl,
           $urandom, $urandom);
    end
    mcu_commit = 1'b1;
    cyc();
    mcu_commit = 1'b0;
    for (int k = 0; k < 200; k++) begin
      j = $urandom_range(0, 4);
      if (j == 4) SNES_ADDR = 24'($urandom);
      else SNES_ADDR = {8'($urandom_range(lo[j], hi[j])), 16'($urandom)};
      if ($urandom_range(0, 5) == 0) SNES_ADDR = ROM_ADDR;
      mcu_rd = ($urandom_range(0, 3) == 0);
      mcu_addr = 6'($urandom);
      cyc();
      checks++;
      if (dutv !== expv() || mcu_rdata !== 8'(m_rdata)) begin
        errors++;
        $display("FAIL rand[%0d] got %h rd %h exp %h rd %h", k, dutv,
                 mcu_rdata, expv(), 8'(m_rdata));
      end
    end
    mcu_rd = 1'b0;
  endtask

  task automatic test_async_reset();
    for (int k = 0; k < 3; k++) begin
      SNES_ADDR = {2'b00, 6'($urandom), 1'b1, 15'($urandom)};
      cyc();
    end
    mcu_commit = 1'b1;
    #2;
    RST = 1'b1;
    #1;
    checks++;
    if (dutv !== '0 || {mcu_rdata, commit_ack} !== 9'h0) begin
      errors++;
      $display("FAIL async_reset got %h exp 0", dutv);
    end
    mcu_commit = 1'b0;
    @(negedge CLK);
    RST = 1'b0;
    model_reset();
    cyc();
    checks++;
    if (commit_ack !== 1'b0) begin
      errors++;
      $display("FAIL lost_commit_ack got %b exp 0", commit_ack);
    end
    for (int k = 0; k < 6; k++) begin
      SNES_ADDR = {2'b00, 6'($urandom), 1'b1, 15'($urandom)};
      cyc();
      checks++;
      if (dutv !== expv() || (k >= 2 && ROM_HIT !== 1'b0)) begin
        errors++;
        $display("FAIL post_reset[%0d] got %h exp %h", k, dutv, expv());
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_passthrough();
    test_program();
    test_two_regions();
    test_shadow();
    test_commit_stream();
    test_stable();
    test_random();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
